// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect scheduler: FSM states, default widths,
// requester indices and default per-effect tone settings.
package sfx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } sfx_state_t;

  localparam int unsigned SFX_NOTE_W = 22;
  localparam int unsigned SFX_DUR_W  = 24;

  // Index 0 is the highest priority.
  localparam int unsigned SFX_HIT   = 0;
  localparam int unsigned SFX_FIRE  = 1;
  localparam int unsigned SFX_SPAWN = 2;
  localparam int unsigned SFX_UI    = 3;

  // Half-period dividers at 100 MHz and play lengths in clk cycles.
  localparam logic [SFX_NOTE_W-1:0] SFX_HIT_DIV   = 22'd113636;
  localparam logic [SFX_NOTE_W-1:0] SFX_FIRE_DIV  = 22'd56818;
  localparam logic [SFX_NOTE_W-1:0] SFX_SPAWN_DIV = 22'd75843;
  localparam logic [SFX_NOTE_W-1:0] SFX_UI_DIV    = 22'd37921;

  localparam logic [SFX_DUR_W-1:0] SFX_HIT_DUR   = 24'd8000000;
  localparam logic [SFX_DUR_W-1:0] SFX_FIRE_DUR  = 24'd3000000;
  localparam logic [SFX_DUR_W-1:0] SFX_SPAWN_DUR = 24'd12000000;
  localparam logic [SFX_DUR_W-1:0] SFX_UI_DUR    = 24'd2000000;

endpackage

// File: rtl/sfx_prio_enc.sv
// Combinational find-first-one: lowest set index of i_vec wins.
module sfx_prio_enc #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_vec,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (i_vec[i] && !o_valid) begin
        o_onehot[i] = 1'b1;
        o_idx       = IDX_W'(i);
        o_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Shares one sound-effect voice between prioritised requesters, with a silent gap
// between effects. Optional preemption by higher priority: SFX_SCHED_PREEMPT_EN.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned NOTE_W  = SFX_NOTE_W,
  parameter int unsigned DUR_W   = SFX_DUR_W,
  parameter int unsigned GAP_CYC = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*NOTE_W-1:0] req_note_div,
  input  logic [N_REQ*DUR_W-1:0]  req_dur,
  output logic [NOTE_W-1:0]       note_div,
  output logic                    sfx_active,
  output logic [N_REQ-1:0]        grant,
  output logic                    drop_pulse
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sfx_state_t        r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_pending, w_pending_nxt;
  logic [DUR_W-1:0]  r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0]  r_grant, w_grant_nxt;
  logic [NOTE_W-1:0] r_note_div, w_note_nxt;
  logic              r_active, w_active_nxt;
  logic              r_drop;

  logic [N_REQ-1:0]  w_cand;
  logic [N_REQ-1:0]  w_onehot;
  logic [IDX_W-1:0]  w_idx;
  logic              w_valid;
  logic [NOTE_W-1:0] w_sel_note;
  logic [DUR_W-1:0]  w_sel_dur;
  logic [DUR_W-1:0]  w_load_cnt;
  logic              w_preempt;
  logic              w_load;

  assign w_cand = r_pending | req;

  sfx_prio_enc #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .i_vec    (w_cand),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  assign w_sel_note = req_note_div[w_idx*NOTE_W +: NOTE_W];
  assign w_sel_dur  = req_dur[w_idx*DUR_W +: DUR_W];
  // A zero duration plays for one cycle.
  assign w_load_cnt = (w_sel_dur == '0) ? '0 : w_sel_dur - DUR_W'(1);

`ifdef SFX_SCHED_PREEMPT_EN
  // Both vectors are one-hot, so a numerically smaller winner has a lower index.
  assign w_preempt = w_valid && (w_onehot < r_grant);
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_grant_nxt  = r_grant;
    w_note_nxt   = r_note_div;
    w_active_nxt = r_active;
    w_load       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_valid) w_load = 1'b1;
      end
      S_PLAY: begin
        if (w_preempt) begin
          w_load = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt  = S_GAP;
          w_cnt_nxt    = DUR_W'(GAP_CYC - 1);
          w_grant_nxt  = '0;
          w_note_nxt   = '0;
          w_active_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - DUR_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - DUR_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_state_nxt  = S_PLAY;
      w_grant_nxt  = w_onehot;
      w_note_nxt   = w_sel_note;
      w_active_nxt = 1'b1;
      w_cnt_nxt    = w_load_cnt;
    end

    w_pending_nxt = w_cand & ~(w_load ? w_onehot : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_note_div <= '0;
      r_active   <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant    <= w_grant_nxt;
      r_note_div <= w_note_nxt;
      r_active   <= w_active_nxt;
      r_drop     <= |(req & r_pending);
    end
  end

  assign note_div   = r_note_div;
  assign sfx_active = r_active;
  assign grant      = r_grant;
  assign drop_pulse = r_drop;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler (N_REQ=4, GAP_CYC=4, DUR_W=8, dividers 100..400).
module tb_sfx_scheduler;
  import sfx_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned NW  = 22;
  localparam int unsigned DW  = 8;
  localparam int unsigned GAP = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*NW-1:0] req_note_div;
  logic [N*DW-1:0] req_dur;
  logic [NW-1:0]   note_div;
  logic            sfx_active;
  logic [N-1:0]    grant;
  logic            drop_pulse;

  int total = 0;
  int bad   = 0;

  sfx_scheduler #(
    .N_REQ   (N),
    .NOTE_W  (NW),
    .DUR_W   (DW),
    .GAP_CYC (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_note_div (req_note_div),
    .req_dur      (req_dur),
    .note_div     (note_div),
    .sfx_active   (sfx_active),
    .grant        (grant),
    .drop_pulse   (drop_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_dur(input int unsigned i, input int unsigned d);
    req_dur[i*DW +: DW] = DW'(d);
  endtask

  task automatic measure_high(input int bound, output int n);
    n = 0;
    while (sfx_active === 1'b1 && n < bound) begin
      n++;
      step();
    end
  endtask

  task automatic measure_low(input int bound, output int n);
    n = 0;
    while (sfx_active !== 1'b1 && n < bound) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req = 4'b1111;
    repeat (4) begin
      step();
      total++;
      if ({note_div, sfx_active, grant, drop_pulse} !== '0) begin
        bad++;
        $display("FAIL reset_hold: note=%0d act=%b grant=%b drop=%b, want all 0",
                 note_div, sfx_active, grant, drop_pulse);
      end
    end
    rst = 1'b1;
    req = '0;
    repeat (6) begin
      step();
      total++;
      if ({note_div, sfx_active, grant, drop_pulse} !== '0) begin
        bad++;
        $display("FAIL reset_idle: note=%0d act=%b grant=%b drop=%b, want all 0",
                 note_div, sfx_active, grant, drop_pulse);
      end
    end
  endtask

  task automatic test_single;
    int n;
    set_dur(SFX_SPAWN, 10);
    req = 4'b0100;
    step();
    req = '0;
    total++;
    if (grant !== 4'b0100 || note_div !== 22'd300 || sfx_active !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: grant=%b note=%0d act=%b, want 0100/300/1", grant, note_div, sfx_active);
    end
    measure_high(50, n);
    total++;
    if (n !== 10) begin bad++; $display("FAIL single_len: got %0d, want 10", n); end
    measure_low(12, n);
    total++;
    if (n !== 12) begin bad++; $display("FAIL single_silent: low run %0d, want 12", n); end
  endtask

  task automatic test_tie;
    int n;
    set_dur(SFX_FIRE, 3);
    set_dur(SFX_UI, 3);
    req = 4'b1010;
    step();
    req = '0;
    total++;
    if (grant !== 4'b0010 || note_div !== 22'd200) begin
      bad++;
      $display("FAIL tie_first: grant=%b note=%0d, want 0010/200", grant, note_div);
    end
    measure_high(50, n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL tie_len1: got %0d, want 3", n); end
    measure_low(20, n);
    total++;
    if (n !== GAP + 1) begin bad++; $display("FAIL tie_gap: got %0d, want %0d", n, GAP + 1); end
    total++;
    if (grant !== 4'b1000 || note_div !== 22'd400) begin
      bad++;
      $display("FAIL tie_second: grant=%b note=%0d, want 1000/400", grant, note_div);
    end
    measure_high(50, n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL tie_len2: got %0d, want 3", n); end
    measure_low(12, n);
  endtask

  task automatic test_preempt;
    int n;
    set_dur(SFX_HIT, 3);
    set_dur(SFX_SPAWN, 10);
    req = 4'b0100;
    step();
    req = '0;
    step();
    step();
    req = 4'b0001;
    step();
    req = '0;
`ifdef SFX_SCHED_PREEMPT_EN
    total++;
    if (grant !== 4'b0001 || note_div !== 22'd100 || sfx_active !== 1'b1) begin
      bad++;
      $display("FAIL preempt_grant: grant=%b note=%0d act=%b, want 0001/100/1", grant, note_div, sfx_active);
    end
    measure_high(50, n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL preempt_len: got %0d, want 3", n); end
    measure_low(30, n);
    total++;
    if (n !== 30) begin bad++; $display("FAIL preempt_noresume: low run %0d, want 30", n); end
`else
    total++;
    if (grant !== 4'b0100 || note_div !== 22'd300) begin
      bad++;
      $display("FAIL nopreempt_hold: grant=%b note=%0d, want 0100/300", grant, note_div);
    end
    measure_high(50, n);
    total++;
    if (n !== 7) begin bad++; $display("FAIL nopreempt_rest: got %0d, want 7", n); end
    measure_low(20, n);
    total++;
    if (n !== GAP + 1) begin bad++; $display("FAIL nopreempt_gap: got %0d, want %0d", n, GAP + 1); end
    total++;
    if (grant !== 4'b0001 || note_div !== 22'd100) begin
      bad++;
      $display("FAIL nopreempt_next: grant=%b note=%0d, want 0001/100", grant, note_div);
    end
    measure_high(50, n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL nopreempt_len: got %0d, want 3", n); end
    measure_low(12, n);
`endif
  endtask

  task automatic test_drop;
    int n;
    set_dur(SFX_FIRE, 6);
    set_dur(SFX_UI, 2);
    req = 4'b0010;
    step();
    req = '0;
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL drop_grant: grant=%b, want 0010", grant); end
    step();
    req = 4'b1000;
    step();
    req = '0;
    total++;
    if (drop_pulse !== 1'b0) begin bad++; $display("FAIL drop_first: drop=%b, want 0", drop_pulse); end
    step();
    req = 4'b1000;
    step();
    req = '0;
    total++;
    if (drop_pulse !== 1'b1) begin bad++; $display("FAIL drop_second: drop=%b, want 1", drop_pulse); end
    step();
    total++;
    if (drop_pulse !== 1'b0) begin bad++; $display("FAIL drop_width: drop=%b, want 0", drop_pulse); end
    measure_high(50, n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL drop_rest: got %0d, want 1", n); end
    measure_low(20, n);
    total++;
    if (n !== GAP + 1 || grant !== 4'b1000 || note_div !== 22'd400) begin
      bad++;
      $display("FAIL drop_next: gap=%0d grant=%b note=%0d, want %0d/1000/400", n, grant, note_div, GAP + 1);
    end
    measure_high(50, n);
    total++;
    if (n !== 2) begin bad++; $display("FAIL drop_len: got %0d, want 2", n); end
    measure_low(30, n);
    total++;
    if (n !== 30) begin bad++; $display("FAIL drop_once: low run %0d, want 30", n); end
  endtask

  task automatic test_reset_mid;
    int n;
    set_dur(SFX_SPAWN, 10);
    req = 4'b0100;
    step();
    req = '0;
    repeat (4) step();
    rst = 1'b0;
    #1;
    total++;
    if (note_div !== '0 || grant !== '0 || sfx_active !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: note=%0d grant=%b act=%b, want 0/0000/0", note_div, grant, sfx_active);
    end
    repeat (3) step();
    rst = 1'b1;
    measure_low(15, n);
    total++;
    if (n !== 15) begin bad++; $display("FAIL reset_lost: low run %0d, want 15", n); end
    req = 4'b0001;
    step();
    req = '0;
    total++;
    if (grant !== 4'b0001 || note_div !== 22'd100) begin
      bad++;
      $display("FAIL reset_newreq: grant=%b note=%0d, want 0001/100", grant, note_div);
    end
    measure_high(50, n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL reset_newlen: got %0d, want 3", n); end
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_note_div[i*NW +: NW] = NW'(100 * (i + 1));
      req_dur[i*DW +: DW]      = DW'(1);
    end
    test_reset();
    test_single();
    test_tie();
    test_preempt();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
